// File: rtl/top_module_split.sv
// Registered 3-bit splitter: one register fanned out as a bus copy and as scalar enables.
// Optional change strobe on port `changed` when TOP_MODULE_CHG_EN is defined.
module top_module_split #(
  parameter logic [2:0] RESET_VAL = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] vec,
  output logic [2:0] out_v,
  output logic       out_0,
  output logic       out_1,
`ifdef TOP_MODULE_CHG_EN
  output logic       out_2,
  output logic       changed
`else
  output logic       out_2
`endif
);

  logic [2:0] vreg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vreg <= RESET_VAL;
    end else begin
      vreg <= vec;
    end
  end

`ifdef TOP_MODULE_CHG_EN
  // vreg still holds the previous load here, so the first load after reset compares against RESET_VAL
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      changed <= 1'b0;
    end else begin
      changed <= (vec != vreg);
    end
  end
`endif

  assign out_v = vreg;
  assign out_0 = vreg[0];
  assign out_1 = vreg[1];
  assign out_2 = vreg[2];

endmodule

// File: tb/tb_top_module_split.sv
// Directed bench for top_module_split; change-strobe steps compile in with TOP_MODULE_CHG_EN.
module tb_top_module_split;

  logic       clk;
  logic       resetn;
  logic [2:0] vec;
  logic [2:0] out_v;
  logic       out_0;
  logic       out_1;
  logic       out_2;
`ifdef TOP_MODULE_CHG_EN
  logic       changed;
`endif

  int n_cmp = 0;
  int n_err = 0;

  top_module_split #(.RESET_VAL(3'b000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .vec    (vec),
    .out_v  (out_v),
    .out_0  (out_0),
    .out_1  (out_1),
`ifdef TOP_MODULE_CHG_EN
    .out_2  (out_2),
    .changed(changed)
`else
    .out_2  (out_2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic check_vec(input string tag, input logic [2:0] exp);
    check_output({tag, "_v"}, out_v, exp);
    check_output({tag, "_bits"}, {out_2, out_1, out_0}, exp);
  endtask

  task automatic apply_stimulus(input logic [2:0] v);
    @(negedge clk);
    vec = v;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] prev;

    // reset applied with no clock edge yet
    resetn = 1'b0;
    vec    = 3'b101;
    #2;
    check_vec("reset_immediate", 3'b000);
`ifdef TOP_MODULE_CHG_EN
    check_output("reset_changed", {2'b00, changed}, 3'b000);
`endif
    // edges while held in reset must ignore vec
    after_edge();
    after_edge();
    check_vec("reset_wins", 3'b000);

    // count sweep, each value held for two edges
    @(negedge clk);
    resetn = 1'b1;
    for (int v = 0; v < 8; v++) begin
      apply_stimulus(3'(v));
      after_edge();
      check_vec($sformatf("sweep%0d_a", v), 3'(v));
      after_edge();
      check_vec($sformatf("sweep%0d_b", v), 3'(v));
    end

    // latency: change just before an edge
    apply_stimulus(3'b000);
    after_edge();
    #3;
    vec = 3'b111;
    #0.5;
    check_vec("latency_before", 3'b000);
    @(posedge clk);
    #1;
    check_vec("latency_after", 3'b111);

    // mid-run asynchronous reset
    apply_stimulus(3'b011);
    after_edge();
    check_vec("pre_reset", 3'b011);
    #1;
    resetn = 1'b0;
    #1;
    check_vec("midrun_reset", 3'b000);
    @(negedge clk);
    resetn = 1'b1;
    vec    = 3'b100;
    after_edge();
    check_vec("post_reset", 3'b100);

`ifdef TOP_MODULE_CHG_EN
    apply_stimulus(3'b010);
    after_edge();
    check_output("chg_hold1", {2'b00, changed}, 3'b001);
    after_edge();
    check_output("chg_hold2", {2'b00, changed}, 3'b000);
    after_edge();
    check_output("chg_hold3", {2'b00, changed}, 3'b000);
    apply_stimulus(3'b001);
    after_edge();
    check_output("chg_step", {2'b00, changed}, 3'b001);
    after_edge();
    check_output("chg_settle", {2'b00, changed}, 3'b000);
    check_vec("chg_value", 3'b001);
`endif

    // random consistency, expected value is the previous vec
    for (int i = 0; i < 1000; i++) begin
      prev = 3'($urandom_range(0, 7));
      apply_stimulus(prev);
      after_edge();
      check_vec("random", prev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
